visited_table: RTL and testbench

Multi-port, parametrised per-vertex state table for the graph-traversal engine. It replaces the single-requester checked/visited RAM and serves up to NUM_PORTS processing elements through one arbitrated pipeline. It supports atomic read-modify-write operations (test-and-set, bit-clear), so two processors cannot both claim the same vertex. It also supports a hardware bulk clear, which zeroes the table at reset and between traversals without an init file.

---
 rtl/visited_table_if.sv | 28 ++
 rtl/visited_table.sv | 189 ++++++++++++++++++
 tb/tb_visited_table.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/visited_table_if.sv
// rtl/visited_table_if.sv - request/response bundle between processing elements and the visited table
interface visited_table_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 2
);
  localparam int PORT_BITS = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]           req_valid_in;
  logic [NUM_PORTS-1:0]           req_ready_out;
  logic [2*NUM_PORTS-1:0]         req_op_in;
  logic [ADDR_BITS*NUM_PORTS-1:0] req_addr_in;
  logic [DATA_BITS*NUM_PORTS-1:0] req_data_in;
  logic                           resp_valid_out;
  logic [PORT_BITS-1:0]           resp_port_out;
  logic [ADDR_BITS-1:0]           resp_addr_out;
  logic [DATA_BITS-1:0]           resp_data_out;

  modport master (
    output req_valid_in, req_op_in, req_addr_in, req_data_in,
    input  req_ready_out, resp_valid_out, resp_port_out, resp_addr_out, resp_data_out
  );

  modport slave (
    input  req_valid_in, req_op_in, req_addr_in, req_data_in,
    output req_ready_out, resp_valid_out, resp_port_out, resp_addr_out, resp_data_out
  );
endinterface

// File: rtl/visited_table.sv
// rtl/visited_table.sv - multi-port per-vertex state table with atomic RMW ops and hardware bulk clear
module visited_table #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  visited_table_if.slave  bus,
  input  logic            clear_in,
  output logic            busy_out,
  output logic            clear_done_out
);
  localparam int PORT_BITS = $clog2(NUM_PORTS);
  localparam int DEPTH     = 2**ADDR_BITS;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam logic [ADDR_BITS:0]   CNT_LAST  = (ADDR_BITS+1)'(DEPTH-1);
  localparam logic [PORT_BITS-1:0] PORT_LAST = PORT_BITS'(NUM_PORTS-1);

  logic [1:0]           state;
  logic [ADDR_BITS:0]   cnt;
  logic [PORT_BITS-1:0] ptr;

  logic [NUM_PORTS-1:0] grant;
  logic                 g_any;
  logic [PORT_BITS-1:0] g_port;
  logic [PORT_BITS-1:0] cand;
  logic [1:0]           g_op;
  logic [ADDR_BITS-1:0] g_addr;
  logic [DATA_BITS-1:0] g_data;

  logic                 s1_v, s2_v;
  logic [PORT_BITS-1:0] s1_port, s2_port;
  logic [1:0]           s1_op, s2_op;
  logic [ADDR_BITS-1:0] s1_addr, s2_addr;
  logic [DATA_BITS-1:0] s1_data, s2_data;

  logic                 r_v;
  logic [PORT_BITS-1:0] r_port;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_pre;
  logic [DATA_BITS-1:0] r_new;

  logic                 f2_v;
  logic [ADDR_BITS-1:0] f2_addr;
  logic [DATA_BITS-1:0] f2_val;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] ram_q;
  logic [DATA_BITS-1:0] pre_val;
  logic [DATA_BITS-1:0] new_val;

  function automatic int rr_idx(input logic [PORT_BITS-1:0] base, input int off);
    return (int'(base) + off) % NUM_PORTS;
  endfunction

  // Round-robin: first valid port at or after ptr wins, only while running.
  always_comb begin
    grant  = '0;
    g_any  = 1'b0;
    g_port = '0;
    cand   = '0;
    g_op   = '0;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_BITS'(rr_idx(ptr, i));
      if (state == ST_RUN && !g_any && bus.req_valid_in[cand]) begin
        g_any       = 1'b1;
        grant[cand] = 1'b1;
        g_port      = cand;
        g_op        = bus.req_op_in[2*cand +: 2];
        g_addr      = bus.req_addr_in[ADDR_BITS*cand +: ADDR_BITS];
        g_data      = bus.req_data_in[DATA_BITS*cand +: DATA_BITS];
      end
    end
  end

  // The RAM read lags the previous op's write by one edge; forward the two youngest results, newest wins.
  always_comb begin
    pre_val = ram_q;
    if (f2_v && f2_addr == s2_addr) pre_val = f2_val;
    if (r_v && r_addr == s2_addr)   pre_val = r_new;
    case (s2_op)
      OP_WRITE: new_val = s2_data;
      OP_SET:   new_val = pre_val | s2_data;
      OP_CLR:   new_val = pre_val & ~s2_data;
      default:  new_val = pre_val;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= ST_SWEEP;
      cnt            <= '0;
      ptr            <= '0;
      clear_done_out <= 1'b0;
      s1_v           <= 1'b0;
      s1_port        <= '0;
      s1_op          <= '0;
      s1_addr        <= '0;
      s1_data        <= '0;
      s2_v           <= 1'b0;
      s2_port        <= '0;
      s2_op          <= '0;
      s2_addr        <= '0;
      s2_data        <= '0;
      r_v            <= 1'b0;
      r_port         <= '0;
      r_addr         <= '0;
      r_pre          <= '0;
      r_new          <= '0;
      f2_v           <= 1'b0;
      f2_addr        <= '0;
      f2_val         <= '0;
    end else begin
      clear_done_out <= 1'b0;

      s1_v    <= g_any;
      s1_port <= g_port;
      s1_op   <= g_op;
      s1_addr <= g_addr;
      s1_data <= g_data;

      s2_v    <= s1_v;
      s2_port <= s1_port;
      s2_op   <= s1_op;
      s2_addr <= s1_addr;
      s2_data <= s1_data;

      r_v <= s2_v;
      if (s2_v) begin
        r_port <= s2_port;
        r_addr <= s2_addr;
        r_pre  <= pre_val;
        r_new  <= new_val;
      end

      f2_v    <= r_v;
      f2_addr <= r_addr;
      f2_val  <= r_new;

      if (g_any) ptr <= (g_port == PORT_LAST) ? '0 : g_port + 1'b1;

      case (state)
        ST_RUN: begin
          if (clear_in) state <= ST_DRAIN;
        end
        // Writes retire from stage 2, so the sweep may start once stages 1 and 2 are empty.
        ST_DRAIN: begin
          if (!s1_v && !s2_v) state <= ST_SWEEP;
        end
        ST_SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            state          <= ST_RUN;
            clear_done_out <= 1'b1;
          end
        end
        default: state <= ST_SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    ram_q <= mem[s1_addr];
    if (state == ST_SWEEP)
      mem[cnt[ADDR_BITS-1:0]] <= '0;
    else if (s2_v && s2_op != OP_READ)
      mem[s2_addr] <= new_val;
  end

  assign bus.req_ready_out  = grant;
  assign bus.resp_valid_out = r_v;
  assign bus.resp_port_out  = r_port;
  assign bus.resp_addr_out  = r_addr;
  assign bus.resp_data_out  = r_pre;
  assign busy_out           = (state != ST_RUN);
endmodule

// File: tb/tb_visited_table.sv
// tb/tb_visited_table.sv - self-checking bench for visited_table
module tb_visited_table;
  localparam int NP    = 4;
  localparam int AB    = 10;
  localparam int DB    = 2;
  localparam int DEPTH = 1 << AB;

  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic clear_in = 1'b0;
  logic busy_out;
  logic clear_done_out;

  visited_table_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  visited_table #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bus            (bus),
    .clear_in       (clear_in),
    .busy_out       (busy_out),
    .clear_done_out (clear_done_out)
  );

  always #5 clk_in = ~clk_in;

  logic          v  [NP];
  logic [1:0]    op [NP];
  logic [AB-1:0] ad [NP];
  logic [DB-1:0] dt [NP];

  always_comb begin
    bus.req_valid_in = '0;
    bus.req_op_in    = '0;
    bus.req_addr_in  = '0;
    bus.req_data_in  = '0;
    for (int p = 0; p < NP; p++) begin
      bus.req_valid_in[p]          = v[p];
      bus.req_op_in[2*p +: 2]      = op[p];
      bus.req_addr_in[AB*p +: AB]  = ad[p];
      bus.req_data_in[DB*p +: DB]  = dt[p];
    end
  end

  typedef struct { int due; int port; int addr; int data; } exp_t;
  typedef struct { int port; int op; int addr; int data; int exp; } vec_t;

  exp_t          q[$];
  logic [DB-1:0] mm [DEPTH];
  int            ptr_m, last_g, cyc, checks, errors;
  bit            run_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) begin
      v[p] = 1'b0; op[p] = '0; ad[p] = '0; dt[p] = '0;
    end
  endtask

  // One clock: check grant, apply accepted op to the model, advance, check the response slot.
  task automatic step(input int ovr);
    exp_t e;
    int   g;
    g = -1;
    #1;
    if (run_m)
      for (int i = 0; i < NP; i++) begin
        int p;
        p = (ptr_m + i) % NP;
        if (g < 0 && v[p]) g = p;
      end
    chk("grant", int'(bus.req_ready_out), (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      e.due  = cyc + 3;
      e.port = g;
      e.addr = int'(ad[g]);
      e.data = (ovr >= 0) ? ovr : int'(mm[ad[g]]);
      q.push_back(e);
      case (op[g])
        2'b01:   mm[ad[g]] = dt[g];
        2'b10:   mm[ad[g]] = mm[ad[g]] | dt[g];
        2'b11:   mm[ad[g]] = mm[ad[g]] & ~dt[g];
        default: ;
      endcase
      ptr_m = (g + 1) % NP;
    end
    last_g = g;
    if (clear_in && run_m) begin
      run_m = 1'b0;
      clear_model();
    end
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("resp_valid", int'(bus.resp_valid_out), 1);
      chk("resp_port",  int'(bus.resp_port_out),  e.port);
      chk("resp_addr",  int'(bus.resp_addr_out),  e.addr);
      chk("resp_data",  int'(bus.resp_data_out),  e.data);
    end else begin
      chk("resp_valid_idle", int'(bus.resp_valid_out), 0);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    chk("rst_ready",      int'(bus.req_ready_out),  0);
    chk("rst_resp_valid", int'(bus.resp_valid_out), 0);
    chk("rst_resp_port",  int'(bus.resp_port_out),  0);
    chk("rst_resp_addr",  int'(bus.resp_addr_out),  0);
    chk("rst_resp_data",  int'(bus.resp_data_out),  0);
    chk("rst_clear_done", int'(clear_done_out),     0);
    chk("rst_busy",       int'(busy_out),           1);
    q.delete();
    ptr_m    = 0;
    run_m    = 1'b0;
    clear_in = 1'b0;
    clear_model();
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
    chk("rst_hold_resp_valid", int'(bus.resp_valid_out), 0);
    rst_in = 1'b1;
  endtask

  task automatic wait_sweep(input int lo, input int hi, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (clear_done_out) begin
        done = 1'b1;
        break;
      end
      if (busy_out) n++;
      step(-1);
    end
    chk({name, "_done"}, int'(done), 1);
    checks++;
    if (n < lo || n > hi) begin
      errors++;
      $display("FAIL %s busy_cycles actual=%0d expected=%0d..%0d", name, n, lo, hi);
    end
    chk({name, "_busy_low"}, int'(busy_out), 0);
    run_m = 1'b1;
  endtask

  vec_t tv [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{2, 0, 'h3FF, 0, 0};
    tv[1]  = '{3, 2, 7, 1, 0};
    tv[2]  = '{3, 2, 7, 2, 1};
    tv[3]  = '{3, 3, 7, 1, 3};
    tv[4]  = '{3, 0, 7, 0, 2};
    tv[5]  = '{1, 1, 20, 3, 0};
    tv[6]  = '{1, 2, 20, 0, 3};
    tv[7]  = '{1, 3, 20, 2, 3};
    tv[8]  = '{1, 0, 20, 0, 1};
    tv[9]  = '{0, 2, 21, 3, 0};
    tv[10] = '{0, 3, 21, 3, 3};
    tv[11] = '{0, 0, 21, 0, 0};
    tv[12] = '{3, 0, 7, 0, 2};

    checks = 0; errors = 0; cyc = 0; last_g = -1;
    idle_inputs();
    for (int p = 0; p < NP; p++) v[p] = 1'b1;
    @(negedge clk_in);
    do_reset();
    idle_inputs();
    wait_sweep(DEPTH, DEPTH, "sweep_initial");
    step(-1);
    chk("clear_done_one_cycle", int'(clear_done_out), 0);

    // Same-cycle contention on one address, pointer at 0.
    v[0] = 1'b1; op[0] = 2'b10; ad[0] = 5; dt[0] = 2'b01;
    v[1] = 1'b1; op[1] = 2'b10; ad[1] = 5; dt[1] = 2'b01;
    step(0);
    chk("tie_first", last_g, 0);
    v[0] = 1'b0;
    step(1);
    chk("tie_second", last_g, 1);
    idle_inputs();

    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      v[tv[i].port]  = 1'b1;
      op[tv[i].port] = 2'(tv[i].op);
      ad[tv[i].port] = AB'(tv[i].addr);
      dt[tv[i].port] = DB'(tv[i].data);
      step(tv[i].exp);
    end

    for (int p = 0; p < NP; p++) begin
      v[p] = 1'b1; op[p] = 2'b00; ad[p] = AB'(100 + p); dt[p] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      step(-1);
      chk("rr_order", last_g, i % NP);
    end
    idle_inputs();

    // Bulk clear with two ops still in flight.
    v[0] = 1'b1; op[0] = 2'b01; ad[0] = 9; dt[0] = 2'b11;
    step(0);
    idle_inputs();
    v[1] = 1'b1; op[1] = 2'b00; ad[1] = 9;
    step(3);
    idle_inputs();
    clear_in = 1'b1;
    step(-1);
    clear_in = 1'b0;
    for (int p = 0; p < NP; p++) begin
      v[p] = 1'b1; op[p] = 2'b00; ad[p] = 9; dt[p] = '0;
    end
    wait_sweep(DEPTH + 1, DEPTH + 3, "sweep_clear");
    step(0);
    chk("clear_ptr_port", last_g, 2);
    chk("clear_done_cleared", int'(clear_done_out), 0);
    idle_inputs();

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++)
        if (!v[p] || last_g == p) begin
          v[p]  = ($urandom_range(0, 3) != 0);
          op[p] = 2'($urandom_range(0, 3));
          ad[p] = AB'($urandom_range(0, 7));
          dt[p] = DB'($urandom_range(0, 3));
        end
      step(-1);
    end
    idle_inputs();
    repeat (4) step(-1);

    // Reset with ops in flight, then again mid-sweep.
    v[0] = 1'b1; op[0] = 2'b01; ad[0] = 30; dt[0] = 2'b11;
    step(-1);
    idle_inputs();
    step(-1);
    do_reset();
    repeat (100) step(-1);
    do_reset();
    wait_sweep(DEPTH, DEPTH, "sweep_restart");
    v[0] = 1'b1; op[0] = 2'b00; ad[0] = 30;
    step(0);
    idle_inputs();
    repeat (4) step(-1);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
